// File: rtl/ram_dp_sweep.sv
// Simple-dual-port RAM with a built-in clear engine that fills every word with CLR_VALUE.
// Optional macro RAM_BYPASS_EN selects write-first behaviour on same-address read/write collisions.
module ram_dp_sweep #(
    parameter int                    DATA_WIDTH = 4,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid
);

    typedef enum logic {SWEEP, RUN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  r_valid_q, r_valid_d;

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    logic                  port_wr;
    logic                  port_rd;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A clear request always restarts the sweep from address 0, even mid-sweep.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SWEEP: begin
                if (clr) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (clr) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q == SWEEP);
        port_wr   = (state_q == RUN) && !clr && wr_en;
        port_rd   = (state_q == RUN) && !clr && rd_en;
        mem_we    = busy || port_wr;
        mem_waddr = busy ? cnt_q : wr_addr;
        mem_wdata = busy ? CLR_VALUE : w_data;
    end

    always_comb begin
        r_data_d  = r_data_q;
        r_valid_d = port_rd;
        if (port_rd) begin
            r_data_d = mem_q[rd_addr];
`ifdef RAM_BYPASS_EN
            if (port_wr && (wr_addr == rd_addr)) begin
                r_data_d = w_data;
            end
`endif
        end
    end

    // The array itself is never reset; the sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
        end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;

endmodule

// File: tb/tb_ram_dp_sweep.sv
// Self-checking bench for ram_dp_sweep: directed scenarios plus randomized traffic
// compared against an array-based memory model.
module tb_ram_dp_sweep;

    localparam int         DW    = 4;
    localparam int         AW    = 8;
    localparam int         DEPTH = 2**AW;
    localparam logic [3:0] CLRV  = 4'hA;

    logic          clk;
    logic          rst;
    logic          clr;
    logic          busy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] w_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] r_data;
    logic          r_valid;

    int            compared;
    int            mismatched;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] expData;

    ram_dp_sweep #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLR_VALUE(CLRV)) dut (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .w_data(w_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .r_data(r_data), .r_valid(r_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; wr_en = 0; rd_en = 0;
        wr_addr = '0; rd_addr = '0; w_data = '0;
    endtask

    task automatic model_cleared();
        for (int i = 0; i < DEPTH; i++) model[i] = CLRV;
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            step();
            n++;
        end
        compared++;
        if (n != DEPTH) begin
            mismatched++;
            $display("[TB] FAIL %s: busy cycles got %0d want %0d", name, n, DEPTH);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step(); step();
        compared++;
        if (busy !== 1'b1 || r_valid !== 1'b0 || r_data !== 4'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: busy=%b r_valid=%b r_data=%h want 1 0 0", busy, r_valid, r_data);
        end
        rst = 0;
        count_busy("reset_sweep_len");
        model_cleared();
        expData = 4'h0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input string name);
        rd_en = 1; rd_addr = a;
        step();
        rd_en = 0;
        expData = model[a];
        compared++;
        if (r_valid !== 1'b1 || r_data !== expData) begin
            mismatched++;
            $display("[TB] FAIL %s: r_valid=%b r_data=%h want 1 %h", name, r_valid, r_data, expData);
        end
        step();
        compared++;
        if (r_valid !== 1'b0 || r_data !== expData) begin
            mismatched++;
            $display("[TB] FAIL %s_hold: r_valid=%b r_data=%h want 0 %h", name, r_valid, r_data, expData);
        end
    endtask

    task automatic test_post_sweep_read();
        do_read(8'h00, "post_sweep_00");
        do_read(8'h7F, "post_sweep_7F");
        do_read(8'hFF, "post_sweep_FF");
    endtask

    task automatic test_write_read();
        wr_en = 1; wr_addr = 8'h12; w_data = 4'h5;
        step();
        wr_en = 0;
        model[8'h12] = 4'h5;
        compared++;
        if (r_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL write_no_valid: r_valid=%b want 0", r_valid);
        end
        do_read(8'h12, "write_read_12");
    endtask

    task automatic test_collision();
        logic [DW-1:0] want;
`ifdef RAM_BYPASS_EN
        want = 4'h3;
`else
        want = model[8'h20];
`endif
        wr_en = 1; wr_addr = 8'h20; w_data = 4'h3;
        rd_en = 1; rd_addr = 8'h20;
        step();
        wr_en = 0; rd_en = 0;
        model[8'h20] = 4'h3;
        expData = want;
        compared++;
        if (r_valid !== 1'b1 || r_data !== want) begin
            mismatched++;
            $display("[TB] FAIL collision: r_valid=%b r_data=%h want 1 %h", r_valid, r_data, want);
        end
        do_read(8'h20, "collision_follow");
    endtask

    task automatic test_back_to_back();
        logic          wr, rd;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        logic          expValid;
        for (int i = 0; i < 400; i++) begin
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 3) != 0);
            wa = (i % 2 == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            ra = (i % 3 == 0) ? wa : AW'($urandom_range(0, 7));
            wd = DW'($urandom);
            wr_en = wr; wr_addr = wa; w_data = wd;
            rd_en = rd; rd_addr = ra;
            expValid = rd;
            if (rd) begin
                expData = model[ra];
`ifdef RAM_BYPASS_EN
                if (wr && wa == ra) expData = wd;
`endif
            end
            if (wr) model[wa] = wd;
            step();
            compared++;
            if (r_valid !== expValid || r_data !== expData) begin
                mismatched++;
                $display("[TB] FAIL random_%0d: r_valid=%b r_data=%h want %b %h", i, r_valid, r_data, expValid, expData);
            end
        end
        idle_inputs();
    endtask

    task automatic test_clr_priority();
        clr = 1; wr_en = 1; wr_addr = 8'h01; w_data = 4'h7;
        rd_en = 1; rd_addr = 8'h01;
        step();
        idle_inputs();
        compared++;
        if (busy !== 1'b1 || r_valid !== 1'b0 || r_data !== expData) begin
            mismatched++;
            $display("[TB] FAIL clr_start: busy=%b r_valid=%b r_data=%h want 1 0 %h", busy, r_valid, r_data, expData);
        end
        count_busy("clr_sweep_len");
        model_cleared();
        do_read(8'h01, "clr_read_01");
        do_read(8'h05, "clr_read_05");
    endtask

    task automatic test_reset_mid_sweep();
        clr = 1;
        step();
        clr = 0;
        for (int i = 0; i < 100; i++) step();
        rst = 1;
        #2;
        compared++;
        if (busy !== 1'b1 || r_data !== 4'h0 || r_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_state: busy=%b r_data=%h r_valid=%b want 1 0 0", busy, r_data, r_valid);
        end
        step();
        rst = 0;
        expData = 4'h0;
        count_busy("mid_reset_sweep_len");
        model_cleared();
        do_read(8'hC3, "mid_reset_read");
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_post_sweep_read();
        test_write_read();
        test_collision();
        test_back_to_back();
        test_clr_priority();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
